// File: rtl/que_sched_ctrl_pkg.sv
// que_pkg: shared constants, index/priority types and scheduler FSM states
package que_pkg;
  localparam int PORTNUM_DEF = 16;
  localparam int PRIOR_DEF = 8;
  typedef logic [$clog2(PORTNUM_DEF)-1:0] port_idx_t;
  typedef logic [$clog2(PRIOR_DEF)-1:0] prior_t;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_SETTLE,
    ST_WAIT_SEL,
    ST_REQ,
    ST_XFER,
    ST_CLEAR
  } sched_state_e;
endpackage

// File: rtl/que_sched_ctrl_if.sv
// que_sched_ctrl_if: queue-manager, arbitrator and read-datapath signals around one scheduler
interface que_sched_ctrl_if #(
  parameter int PORTNUM = 16,
  parameter int PRIOR = 8
) ();
  localparam int PW = $clog2(PORTNUM);
  localparam int RW = $clog2(PRIOR);
  logic [PORTNUM-1:0] i_que_pending;
  logic [PORTNUM-1:0][RW-1:0] i_que_prior;
  logic [PORTNUM-1:0] o_pending;
  logic [PORTNUM-1:0][RW-1:0] o_prior;
  logic o_update;
  logic [PW-1:0] i_port;
  logic i_port_vld;
  logic i_empty;
  logic [PW-1:0] o_clr_port;
  logic o_clr_vld;
  logic o_rd_req;
  logic [PW-1:0] o_rd_port;
  logic i_rd_ack;
  logic i_rd_done;
  modport ctrl (
    input i_que_pending, i_que_prior, i_port, i_port_vld, i_empty, i_rd_ack, i_rd_done,
    output o_pending, o_prior, o_update, o_clr_port, o_clr_vld, o_rd_req, o_rd_port
  );
  modport peer (
    output i_que_pending, i_que_prior, i_port, i_port_vld, i_empty, i_rd_ack, i_rd_done,
    input o_pending, o_prior, o_update, o_clr_port, o_clr_vld, o_rd_req, o_rd_port
  );
endinterface

// File: rtl/que_sched_ctrl.sv
// que_sched_ctrl: snapshots queue status, drives arbitrator update/clear and per-packet reads.
// Define QUE_SCHED_WDOG_EN to add the REQ/XFER watchdog and its o_wdog_err pulse.
module que_sched_ctrl
  import que_pkg::*;
#(
  parameter int PORTNUM = PORTNUM_DEF,
  parameter int PRIOR = PRIOR_DEF,
  parameter int WDOG_CYC = 1024
) (
  input logic i_clk,
  input logic i_rst_n,
  que_sched_ctrl_if.ctrl bus,
  output logic o_busy,
  output logic [15:0] o_round_cnt
`ifdef QUE_SCHED_WDOG_EN
  ,
  output logic o_wdog_err
`endif
);
  localparam int PW = $clog2(PORTNUM);
  localparam int RW = $clog2(PRIOR);
  sched_state_e state, nxt;
  logic [PORTNUM-1:0] pending;
  logic [PORTNUM-1:0][RW-1:0] prior;
  logic [PW-1:0] rd_port;
  logic wdog_hit;
  logic load, take, done_round;
  assign load = (state == ST_IDLE) && |bus.i_que_pending;
  assign take = (state == ST_WAIT_SEL) && bus.i_port_vld;
  assign done_round = (state == ST_WAIT_SEL) && !bus.i_port_vld && bus.i_empty;
  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.o_update = state == ST_UPDATE;
  assign bus.o_clr_vld = state == ST_CLEAR;
  assign bus.o_rd_req = state == ST_REQ;
  assign bus.o_clr_port = rd_port;
  assign bus.o_rd_port = rd_port;
  assign bus.o_pending = pending;
  assign bus.o_prior = prior;
  assign o_busy = state != ST_IDLE;
`ifdef QUE_SCHED_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] wcnt;
  assign wdog_hit = (state == ST_REQ || state == ST_XFER) && wcnt == CW'(WDOG_CYC - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wcnt <= '0;
      o_wdog_err <= 1'b0;
    end else begin
      wcnt <= (nxt == ST_REQ && state != ST_REQ) ? '0 : (state == ST_REQ || state == ST_XFER) ? wcnt + 1'b1 : wcnt;
      o_wdog_err <= wdog_hit;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: nxt = |bus.i_que_pending ? ST_UPDATE : ST_IDLE;
      ST_UPDATE: nxt = ST_SETTLE;
      ST_SETTLE: nxt = ST_WAIT_SEL;
      ST_WAIT_SEL: nxt = bus.i_port_vld ? ST_REQ : bus.i_empty ? ST_IDLE : ST_WAIT_SEL;
      ST_REQ: nxt = bus.i_rd_ack ? (bus.i_rd_done ? ST_CLEAR : ST_XFER) : ST_REQ;
      ST_XFER: nxt = bus.i_rd_done ? ST_CLEAR : ST_XFER;
      ST_CLEAR: nxt = ST_SETTLE;
      default: nxt = ST_IDLE;
    endcase
    if (wdog_hit) nxt = ST_CLEAR;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      pending <= '0;
      prior <= '0;
      rd_port <= '0;
      o_round_cnt <= '0;
    end else begin
      state <= nxt;
      if (load) begin
        pending <= bus.i_que_pending;
        prior <= bus.i_que_prior;
      end
      if (take) rd_port <= bus.i_port;
      if (done_round) o_round_cnt <= o_round_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_que_sched_ctrl.sv
// tb_que_sched_ctrl: directed checks of one scheduling round, ack+done, snapshot hold, SETTLE masking,
// mid-transfer reset and (with QUE_SCHED_WDOG_EN) the watchdog.
module tb_que_sched_ctrl;
  import que_pkg::*;
  logic i_clk = 1'b0;
  logic i_rst_n;
  logic busy;
  logic [15:0] rcnt;
`ifdef QUE_SCHED_WDOG_EN
  logic wdog;
`endif
  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  always #5 i_clk = ~i_clk;
  que_sched_ctrl_if #(.PORTNUM(16), .PRIOR(8)) bus ();
  que_sched_ctrl #(.PORTNUM(16), .PRIOR(8), .WDOG_CYC(8)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .bus(bus),
    .o_busy(busy),
    .o_round_cnt(rcnt)
`ifdef QUE_SCHED_WDOG_EN
    ,
    .o_wdog_err(wdog)
`endif
  );
  always @(negedge i_clk) if (bus.o_update === 1'b1) upd_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic grant(input port_idx_t p);
    bus.i_port = p;
    bus.i_port_vld = 1'b1;
  endtask
  initial begin
    bus.i_que_pending = '0;
    bus.i_que_prior = '0;
    bus.i_port = '0;
    bus.i_port_vld = 1'b0;
    bus.i_empty = 1'b0;
    bus.i_rd_ack = 1'b0;
    bus.i_rd_done = 1'b0;
    i_rst_n = 1'b0;
    #12;
    chk("rst_update", 32'(bus.o_update), 0);
    chk("rst_clr_vld", 32'(bus.o_clr_vld), 0);
    chk("rst_rd_req", 32'(bus.o_rd_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_round", 32'(rcnt), 0);
    chk("rst_pending", 32'(bus.o_pending), 0);
    step();
    i_rst_n = 1'b1;
    bus.i_que_pending = 16'h0005;
    bus.i_que_prior[0] = 3'd3;
    bus.i_que_prior[2] = 3'd3;
    step();
    chk("r1_update", 32'(bus.o_update), 1);
    chk("r1_pending", 32'(bus.o_pending), 32'h5);
    chk("r1_prior0", 32'(bus.o_prior[0]), 3);
    chk("r1_prior2", 32'(bus.o_prior[2]), 3);
    chk("r1_busy", 32'(busy), 1);
    step();
    chk("r1_settle_upd", 32'(bus.o_update), 0);
    grant(4'd0);
    step();
    chk("r1_waitsel_req", 32'(bus.o_rd_req), 0);
    step();
    chk("r1_req0", 32'(bus.o_rd_req), 1);
    chk("r1_rdport0", 32'(bus.o_rd_port), 0);
    bus.i_port_vld = 1'b0;
    bus.i_rd_ack = 1'b1;
    step();
    chk("r1_xfer_req", 32'(bus.o_rd_req), 0);
    bus.i_rd_ack = 1'b0;
    step();
    chk("r1_xfer_noclr", 32'(bus.o_clr_vld), 0);
    bus.i_rd_done = 1'b1;
    step();
    chk("r1_clr0", 32'(bus.o_clr_vld), 1);
    chk("r1_clrport0", 32'(bus.o_clr_port), 0);
    chk("r1_clr_noupd", 32'(bus.o_update), 0);
    bus.i_rd_done = 1'b0;
    step();
    chk("r1_clr0_end", 32'(bus.o_clr_vld), 0);
    grant(4'd2);
    step();
    step();
    chk("r1_rdport2", 32'(bus.o_rd_port), 2);
    chk("r1_req2", 32'(bus.o_rd_req), 1);
    bus.i_port_vld = 1'b0;
    bus.i_rd_ack = 1'b1;
    step();
    bus.i_rd_ack = 1'b0;
    bus.i_rd_done = 1'b1;
    step();
    chk("r1_clr2", 32'(bus.o_clr_vld), 1);
    chk("r1_clrport2", 32'(bus.o_clr_port), 2);
    bus.i_rd_done = 1'b0;
    bus.i_que_pending = '0;
    bus.i_empty = 1'b1;
    step();
    step();
    chk("r1_round_pre", 32'(rcnt), 0);
    step();
    chk("r1_round", 32'(rcnt), 1);
    chk("r1_idle", 32'(busy), 0);
    chk("r1_upd_once", 32'(upd_cnt), 1);
    bus.i_empty = 1'b0;
    bus.i_que_prior = '0;
    bus.i_que_pending = 16'h0001;
    step();
    chk("r2_pending", 32'(bus.o_pending), 32'h1);
    bus.i_que_pending = 16'h8001;
    step();
    bus.i_empty = 1'b1;
    step();
    chk("r2_settle_empty_ign", 32'(busy), 1);
    grant(4'd0);
    step();
    chk("r2_grant_taken", 32'(bus.o_rd_req), 1);
    chk("r2_not_counted", 32'(rcnt), 1);
    bus.i_port_vld = 1'b0;
    bus.i_empty = 1'b0;
    bus.i_rd_ack = 1'b1;
    bus.i_rd_done = 1'b1;
    step();
    chk("r2_ackdone_clr", 32'(bus.o_clr_vld), 1);
    chk("r2_ackdone_noreq", 32'(bus.o_rd_req), 0);
    chk("r2_pending_hold", 32'(bus.o_pending), 32'h1);
    bus.i_rd_ack = 1'b0;
    bus.i_rd_done = 1'b0;
    bus.i_empty = 1'b1;
    step();
    step();
    step();
    chk("r2_round", 32'(rcnt), 2);
    bus.i_empty = 1'b0;
    step();
    chk("r3_pending_new", 32'(bus.o_pending), 32'h8001);
    chk("r3_update", 32'(bus.o_update), 1);
    step();
    grant(4'd15);
    step();
    step();
    chk("r3_rdport15", 32'(bus.o_rd_port), 15);
    bus.i_port_vld = 1'b0;
    bus.i_rd_ack = 1'b1;
    step();
    bus.i_rd_ack = 1'b0;
    chk("r3_xfer_busy", 32'(busy), 1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(bus.o_rd_req), 0);
    chk("rst_mid_clr", 32'(bus.o_clr_vld), 0);
    chk("rst_mid_idle", 32'(busy), 0);
    chk("rst_mid_round", 32'(rcnt), 0);
    bus.i_que_pending = '0;
    step();
    i_rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(busy), 0);
`ifdef QUE_SCHED_WDOG_EN
    bus.i_que_pending = 16'h0008;
    step();
    step();
    grant(4'd3);
    step();
    step();
    bus.i_port_vld = 1'b0;
    bus.i_que_pending = '0;
    chk("wd_req", 32'(bus.o_rd_req), 1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("wd_early_err", 32'(wdog), 0);
      chk("wd_early_clr", 32'(bus.o_clr_vld), 0);
    end
    step();
    chk("wd_err", 32'(wdog), 1);
    chk("wd_clr", 32'(bus.o_clr_vld), 1);
    chk("wd_clrport", 32'(bus.o_clr_port), 3);
    chk("wd_req_drop", 32'(bus.o_rd_req), 0);
    step();
    chk("wd_err_pulse", 32'(wdog), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
